poly1305_p_tag: RTL and testbench
=================================

// Module: poly1305_p_tag
// PURPOSE
//  Poly1305 one-time authenticator (RFC 8439 s2.5) for the ChaCha20-Poly1305 datapath.
//  Takes a 256-bit one-time key and a message streamed as 128-bit blocks on request.
//  Outputs the 128-bit tag: tag = ((sum of padded blocks Horner-multiplied by r) mod 2^130-5 + s) mod 2^128.
// PARAMETERS
//  none (all widths fixed by Poly1305)
// PORTS
//  i_clk      in   1    clock; single clock domain
//  i_rstn     in   1    reset, synchronous, active-low
//  i_start    in   1    1-cycle pulse: latch i_key, i_len_msg, i_msg (first block), begin
//  i_sig_msg  in   1    1-cycle pulse: i_msg holds next block (answer to o_sig_msg)
//  i_key      in   256  [127:0]=r (little-endian number, clamped internally), [255:128]=s
//  i_msg      in   128  block; message byte k at bits [8k+7:8k]
//  i_len_msg  in   32   total message length in bytes
//  o_sig_msg  out  1    1-cycle pulse: block absorbed, next block wanted
//  o_tag      out  128  tag; tag byte k at bits [8k+7:8k]
//  o_done     out  1    1-cycle pulse: o_tag valid
// BEHAVIOUR
//  - Reset (i_rstn=0 at posedge): FSM->IDLE, all regs 0, o_sig_msg=o_done=0, o_tag=0. Mid-operation reset aborts.
//  - r clamp: r &= 0x0ffffffc_0ffffffc_0ffffffc_0fffffff. Accumulator h cleared on i_start.
//  - Blocks N=ceil(len/16). Full block: m = block + 2^128. Final partial block of n bytes (1..15):
//    bytes >= n forced to 0, m = block_masked + 2^(8n).
//  - Per block: h = ((h + m) * r) mod p, p = 2^130-5. Internal datapath 32-bit limbs with multi-cycle
//    add / schoolbook multiply / carry propagation; fold bits >=130 as hi*5 (hi + hi<<2) repeatedly
//    until h < 2^130 (partial reduction).
//  - Final: compute h+5; if bit 130 set, h = (h+5) mod 2^130 (i.e. h-p), else keep h. tag = (h + s) mod 2^128.
//  - FSM (3-bit): 0 IDLE, 1 ADD (h+=m), 2 MUL (h*=r), 3 MOD1 (fold >=2^130), 4 WAIT (await i_sig_msg),
//    5 MOD2 (final h-p select), 6 ADD2 (h+s), 7 DONE.
//    IDLE--i_start-->ADD->MUL->MOD1; MOD1->WAIT if blocks remain (o_sig_msg pulses on entry), else ->MOD2;
//    WAIT--i_sig_msg (latch i_msg)-->ADD; MOD2->ADD2->DONE; DONE pulses o_done 1 cycle ->IDLE.
//  - len=0: no blocks; IDLE->MOD2 directly, tag = s.
//  - Per-block latency ADD..MOD1 <= 40 cycles; MOD2..DONE <= 16 cycles.
//  - Host may delay i_sig_msg arbitrarily; WAIT holds state indefinitely.
//  - i_start outside IDLE ignored; i_sig_msg outside WAIT ignored; i_start and i_sig_msg both high
//    in IDLE: i_start wins.
//  - o_tag holds last tag until next completion or reset (not cleared by i_start).
// TESTING
//  - RFC 8439 2.5.2: i_key=1bf54941_aff6bf4a_fdb20dfb_8a800301_a806d542_fe52447f_336d5557_78bed685,
//    len=34, blocks 6f462063_69687061_72676f74_70797243, 6f724720_68637261_65736552_206d7572,
//    0..0_00007075 -> 2 o_sig_msg pulses, o_done, o_tag=a927010c_af8b2bc2_c6365130_c11d06a8.
//  - r=1 (i_key[127:0]=1), s=0, len=16, i_msg=X -> o_tag=X; len=1, i_msg=..FF_AB -> o_tag=0x1AB (mask check).
//  - i_key[127:0]=0, s=S, any len/msg -> o_tag=S; len=0 -> o_tag=S with no o_sig_msg pulse.
//  - Repeat RFC vector with i_sig_msg delayed 1 and 50 cycles after o_sig_msg -> same tag.
//  - i_start pulses during MUL and WAIT -> ignored, RFC tag unchanged.
//  - i_rstn low during MUL -> o_tag=0, o_done=0, IDLE; fresh RFC run afterwards gives correct tag.

Source files
------------

// File: rtl/poly1305_p_tag.sv
// Poly1305 one-time authenticator. The FSM steps through ADD (h+=m), MUL (h*=r, one 32-bit limb of r per
// cycle), MOD1 (fold >=2^130 as *5), WAIT (next block), then MOD2 (h-p select), ADD2 (h+s) and DONE.
module poly1305_p_tag (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic         i_sig_msg,
    input  logic [255:0] i_key,
    input  logic [127:0] i_msg,
    input  logic [31:0]  i_len_msg,
    output logic         o_sig_msg,
    output logic [127:0] o_tag,
    output logic         o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_MUL  = 3'd2,
        S_MOD1 = 3'd3,
        S_WAIT = 3'd4,
        S_MOD2 = 3'd5,
        S_ADD2 = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    state_t         state_q, state_d;
    logic [130:0]   h_q;
    logic [259:0]   prod_q;
    logic [127:0]   r_q, s_q, msg_q, tag_q;
    logic [31:0]    rem_q;
    logic [1:0]     cnt_q;
    logic           sig_q;

    logic           full;
    logic [4:0]     nb;
    logic [7:0]     one_idx;
    logic [130:0]   m_blk;
    logic [31:0]    r_limb;
    logic [162:0]   pp;
    logic [259:0]   pp_sh;
    logic [259:0]   fold_val;
    logic           fold_done;
    logic [130:0]   h5;

    // Padded block: keep the first nb bytes and place the 0x01 pad right after them.
    always_comb begin
        full    = (rem_q >= 32'd16);
        nb      = full ? 5'd16 : {1'b0, rem_q[3:0]};
        one_idx = {nb, 3'b000};
        m_blk   = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < nb) m_blk[8*k +: 8] = msg_q[8*k +: 8];
        end
        m_blk[one_idx] = 1'b1;
    end

    always_comb begin
        r_limb    = r_q[{cnt_q, 5'b00000} +: 32];
        pp        = {32'b0, h_q} * {131'b0, r_limb};
        pp_sh     = {97'b0, pp} << {cnt_q, 5'b00000};
        fold_val  = {130'b0, prod_q[129:0]} + {130'b0, prod_q[259:130]}
                  + {128'b0, prod_q[259:130], 2'b00};
        fold_done = (prod_q[259:130] == '0);
        h5        = h_q + 131'd5;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start) state_d = (i_len_msg == 32'd0) ? S_MOD2 : S_ADD;
            S_ADD:  state_d = S_MUL;
            S_MUL:  if (cnt_q == 2'd3) state_d = S_MOD1;
            S_MOD1: if (fold_done) state_d = (rem_q != 32'd0) ? S_WAIT : S_MOD2;
            S_WAIT: if (i_sig_msg) state_d = S_ADD;
            S_MOD2: state_d = S_ADD2;
            S_ADD2: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            h_q    <= '0;
            prod_q <= '0;
            r_q    <= '0;
            s_q    <= '0;
            msg_q  <= '0;
            tag_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            sig_q  <= 1'b0;
        end else begin
            sig_q <= (state_q == S_MOD1) && (state_d == S_WAIT);
            case (state_q)
                S_IDLE: if (i_start) begin
                    r_q   <= i_key[127:0] & R_CLAMP;
                    s_q   <= i_key[255:128];
                    msg_q <= i_msg;
                    rem_q <= i_len_msg;
                    h_q   <= '0;
                    cnt_q <= '0;
                end
                S_ADD: begin
                    h_q    <= h_q + m_blk;
                    rem_q  <= full ? (rem_q - 32'd16) : 32'd0;
                    prod_q <= '0;
                    cnt_q  <= '0;
                end
                S_MUL: begin
                    prod_q <= prod_q + pp_sh;
                    cnt_q  <= cnt_q + 2'd1;
                end
                S_MOD1: begin
                    if (!fold_done) prod_q <= fold_val;
                    else            h_q    <= prod_q[130:0];
                end
                S_WAIT: if (i_sig_msg) msg_q <= i_msg;
                // h+5 reaching 2^130 means h >= p, so h-p is the low 130 bits of h+5.
                S_MOD2: if (h5[130]) h_q <= {1'b0, h5[129:0]};
                S_ADD2: tag_q <= h_q[127:0] + s_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_sig_msg = sig_q;
        o_done    = (state_q == S_DONE);
        o_tag     = tag_q;
    end

endmodule

// File: tb/tb_poly1305_p_tag.sv
// Directed bench for poly1305_p_tag: RFC 8439 vector, r=1 / r=0 identities, pad masking, host delays,
// ignored i_start, and mid-run reset.
module tb_poly1305_p_tag;

    logic         clk = 1'b0;
    logic         rstn, start, sig_in, sig_out, done;
    logic [255:0] key;
    logic [127:0] msg, tag;
    logic [31:0]  len;

    int total = 0;
    int bad   = 0;
    int sig_cnt  = 0;
    int done_cnt = 0;

    logic [127:0] blk [0:3];
    logic [127:0] last_tag = '0;

    localparam logic [255:0] RFC_KEY =
        256'h1bf54941aff6bf4afdb20dfb8a800301a806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [127:0] GARB    = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] S_VAL   = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    poly1305_p_tag dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_start   (start),
        .i_sig_msg (sig_in),
        .i_key     (key),
        .i_msg     (msg),
        .i_len_msg (len),
        .o_sig_msg (sig_out),
        .o_tag     (tag),
        .o_done    (done)
    );

    always @(negedge clk) begin
        if (sig_out) sig_cnt++;
        if (done)    done_cnt++;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rfc();
        blk[0] = 128'h6f4620636968706172676f7470797243;
        blk[1] = 128'h6f7247206863726165736552206d7572;
        blk[2] = 128'h00000000000000000000000000007075;
        blk[3] = GARB;
    endtask

    task automatic run(input string nm, input logic [255:0] k, input logic [31:0] l, input int dly,
                       input bit inj, input logic [127:0] exp);
        int  sig0, exp_p, bi;
        bit  seen;
        sig0  = sig_cnt;
        exp_p = (l == 0) ? 0 : int'((l + 32'd15) / 32'd16) - 1;
        tick();
        start = 1'b1; key = k; len = l; msg = blk[0];
        tick();
        start = 1'b0; msg = GARB; key = '1;
        chk({nm, ":hold"}, tag, last_tag);
        if (inj) begin
            start = 1'b1; len = 32'd0;
            tick();
            start = 1'b0;
        end
        bi = 1;
        seen = 1'b0;
        for (int b = 0; b < 600 && !seen; b++) begin
            if (done) begin
                seen = 1'b1;
            end else if (sig_out) begin
                if (inj) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                repeat (dly) tick();
                sig_in = 1'b1; msg = blk[bi]; bi++;
                tick();
                sig_in = 1'b0; msg = GARB;
            end else begin
                tick();
            end
        end
        chk({nm, ":done"}, 128'(seen), 128'(1));
        chk({nm, ":tag"}, tag, exp);
        chk({nm, ":pulses"}, 128'(sig_cnt - sig0), 128'(exp_p));
        tick();
        chk({nm, ":done1cyc"}, 128'(done), 128'(0));
        last_tag = exp;
    endtask

    initial begin
        int d0;
        rstn = 1'b0; start = 1'b0; sig_in = 1'b0; key = '0; msg = '0; len = '0;
        repeat (2) tick();
        chk("rst_tag", tag, '0);
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_sig", 128'(sig_out), 128'(0));
        rstn = 1'b1;
        tick();

        load_rfc();
        run("rfc", RFC_KEY, 32'd34, 0, 1'b0, RFC_TAG);

        blk[0] = 128'h0123456789abcdeffedcba9876543210;
        run("r1", {128'h0, 128'h1}, 32'd16, 0, 1'b0, 128'h0123456789abcdeffedcba9876543210);

        blk[0] = 128'hffffffffffffffffffffffffffffffab;
        run("mask", {128'h0, 128'h1}, 32'd1, 0, 1'b0, 128'h1ab);

        blk[0] = 128'h11111111222222223333333344444444;
        blk[1] = 128'h55555555666666667777777788888888;
        blk[2] = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
        run("r0", {S_VAL, 128'h0}, 32'd40, 0, 1'b0, S_VAL);
        run("len0", {S_VAL, 128'hffffffffffffffffffffffffffffffff}, 32'd0, 0, 1'b0, S_VAL);

        load_rfc();
        run("rfc_d1", RFC_KEY, 32'd34, 1, 1'b0, RFC_TAG);
        run("rfc_d50", RFC_KEY, 32'd34, 50, 1'b0, RFC_TAG);
        run("rfc_inj", RFC_KEY, 32'd34, 2, 1'b1, RFC_TAG);

        tick();
        start = 1'b1; key = RFC_KEY; len = 32'd34; msg = blk[0];
        tick();
        start = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst_tag", tag, '0);
        chk("mrst_done", 128'(done), 128'(0));
        d0 = done_cnt;
        repeat (60) tick();
        chk("mrst_idle", 128'(done_cnt - d0), 128'(0));
        chk("mrst_sig", 128'(sig_out), 128'(0));
        last_tag = '0;
        run("rfc_after_rst", RFC_KEY, 32'd34, 0, 1'b0, RFC_TAG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
